// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: bitslip-driven word alignment, control-token lock, 10b->8b decode.
// Optional lock-loss counter on err_cnt is enabled by defining TMDS_ERRCNT_EN.
module tmds_channel_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4400,
    parameter int SLIP_WAIT      = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [9:0]  raw_word,
    input  logic        raw_valid,
    output logic        bitslip,
    output logic [3:0]  slip_cnt,
    output logic        aligned,
    output logic        out_valid,
    output logic        de_out,
    output logic [1:0]  ctrl_out,
    output logic [7:0]  data_out,
    input  logic        err_clr,
    output logic [15:0] err_cnt
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int GAP_W  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [RUN_W-1:0]   run_cnt, run_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               lock_lost;

    logic               is_tok;
    logic [1:0]         tok_ctrl;
    logic               s1_vld, s1_tok;
    logic [1:0]         s1_ctrl;
    logic [9:0]         s1_word;
    logic [7:0]         dec_d, dec_byte;

    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (raw_word)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: is_tok   = 1'b0;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            s1_vld  <= 1'b0;
            s1_tok  <= 1'b0;
            s1_ctrl <= 2'b00;
            s1_word <= '0;
        end else begin
            s1_vld  <= raw_valid;
            s1_tok  <= is_tok;
            s1_ctrl <= tok_ctrl;
            s1_word <= raw_word;
        end
    end

    always_comb begin
        dec_d       = s1_word[9] ? ~s1_word[7:0] : s1_word[7:0];
        dec_byte    = '0;
        dec_byte[0] = dec_d[0];
        for (int i = 1; i < 8; i++)
            dec_byte[i] = s1_word[8] ? (dec_d[i] ^ dec_d[i-1]) : ~(dec_d[i] ^ dec_d[i-1]);
    end

    // aligned is the post-transition state, so the word that caused a lock
    // change already leaves stage 2 with the new qualification.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            de_out    <= 1'b0;
            ctrl_out  <= 2'b00;
            data_out  <= 8'h00;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                if (!aligned) begin
                    de_out   <= 1'b0;
                    ctrl_out <= 2'b00;
                    data_out <= 8'h00;
                end else if (s1_tok) begin
                    de_out   <= 1'b0;
                    ctrl_out <= s1_ctrl;
                    data_out <= 8'h00;
                end else begin
                    de_out   <= 1'b1;
                    data_out <= dec_byte;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        tmo_nxt   = tmo_cnt;
        wait_nxt  = wait_cnt;
        gap_nxt   = gap_cnt;
        lock_lost = 1'b0;
        case (state)
            SEARCH: if (raw_valid) begin
                run_nxt = is_tok ? run_cnt + RUN_W'(1) : '0;
                tmo_nxt = tmo_cnt + TMO_W'(1);
                if (run_nxt == RUN_W'(CTRL_RUN))
                    state_nxt = LOCKED;
                else if (tmo_nxt == TMO_W'(SEARCH_TIMEOUT))
                    state_nxt = SLIP;
            end
            SLIP: state_nxt = WAIT;
            WAIT: if (raw_valid) begin
                if (wait_cnt == WAIT_W'(SLIP_WAIT - 1))
                    state_nxt = SEARCH;
                else
                    wait_nxt = wait_cnt + WAIT_W'(1);
            end
            LOCKED: if (raw_valid) begin
                gap_nxt = is_tok ? '0 : gap_cnt + GAP_W'(1);
                if (gap_nxt == GAP_W'(LOCK_TIMEOUT)) begin
                    state_nxt = SEARCH;
                    lock_lost = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        // Every state entry starts from clean counters.
        if (state_nxt != state) begin
            run_nxt  = '0;
            tmo_nxt  = '0;
            wait_nxt = '0;
            gap_nxt  = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            slip_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            tmo_cnt  <= tmo_nxt;
            wait_cnt <= wait_nxt;
            gap_cnt  <= gap_nxt;
            if (state == SLIP)
                slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
        end
    end

    assign bitslip = (state == SLIP);
    assign aligned = (state == LOCKED);

`ifdef TMDS_ERRCNT_EN
    always_ff @(posedge pixel_clk) begin
        if (sys_rst || err_clr)
            err_cnt <= 16'h0000;
        else if (lock_lost && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'h0001;
    end
`else
    logic unused_err;
    assign unused_err = err_clr ^ lock_lost;
    assign err_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: lock, decode, slip search, lock loss, reset.
module tb_tmds_channel_decoder;

    localparam int CR = 8, ST = 64, SW = 16, LT = 4096;
`ifdef TMDS_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        pixel_clk = 1'b0;
    logic        sys_rst   = 1'b1;
    logic [9:0]  raw_word  = '0;
    logic        raw_valid = 1'b0;
    logic        err_clr   = 1'b0;
    logic        bitslip, aligned, out_valid, de_out;
    logic [3:0]  slip_cnt;
    logic [1:0]  ctrl_out;
    logic [7:0]  data_out;
    logic [15:0] err_cnt;

    tmds_channel_decoder #(.CTRL_RUN(CR), .SEARCH_TIMEOUT(ST), .SLIP_WAIT(SW), .LOCK_TIMEOUT(LT)) dut (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .raw_word(raw_word), .raw_valid(raw_valid),
        .bitslip(bitslip), .slip_cnt(slip_cnt), .aligned(aligned), .out_valid(out_valid),
        .de_out(de_out), .ctrl_out(ctrl_out), .data_out(data_out),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed { logic de; logic [1:0] ctrl; logic [7:0] data; } exp_t;
    exp_t sb[$];
    int   slip_times[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, slip_seen = 0, rot = 0;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per out_valid; tracks bitslip and the model rotation.
    always @(negedge pixel_clk) begin
        exp_t e;
        if (bitslip === 1'b1) begin
            slip_seen++;
            slip_times.push_back(cyc);
            rot = (rot + 1) % 10;
        end
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=out_valid expected=no_output (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("de_out", de_out, e.de);
                check("ctrl_out", ctrl_out, e.ctrl);
                check("data_out", data_out, e.data);
            end
        end
    end

    function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
        logic [9:0] x = w;
        for (int i = 0; i < r; i++) x = {x[8:0], x[9]};
        return x;
    endfunction

    task automatic send(input logic [9:0] w, input logic de, input logic [1:0] c,
                        input logic [7:0] d, input logic clr = 1'b0);
        @(posedge pixel_clk); #1;
        raw_word  = w;
        raw_valid = 1'b1;
        err_clr   = clr;
        sb.push_back({de, c, d});
    endtask

    task automatic idle();
        @(posedge pixel_clk); #1;
        raw_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_de"}, de_out, 0);
        check({tag, "_ctrl"}, ctrl_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_bitslip"}, bitslip, 0);
        check({tag, "_slip_cnt"}, slip_cnt, 0);
        check({tag, "_aligned"}, aligned, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge pixel_clk); #1;
        sys_rst = 1'b1; raw_valid = 1'b0; err_clr = 1'b0;
        @(posedge pixel_clk); #1;
        sys_rst = 1'b0;
        sb.delete();
        slip_seen = 0;
        slip_times.delete();
    endtask

    task automatic lock();
        for (int i = 0; i < CR; i++) send(10'h354, 0, 2'b00, 8'h00);
        idle();
        check("lock_aligned", aligned, 1);
    endtask

    // Token, LT-1 data words (still locked), then the word that drops lock.
    task automatic lose(input logic clr_last);
        send(10'h354, 0, 2'b00, 8'h00);
        for (int i = 0; i < LT - 1; i++) send(10'h100, 1, 2'b00, 8'h00);
        idle();
        check("loss_hold_aligned", aligned, 1);
        send(10'h100, 0, 2'b00, 8'h00, clr_last);
        idle();
        check("loss_aligned", aligned, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_all_zero("reset");
        sys_rst = 1'b0;

        // Lock on CTRL_RUN tokens, not one earlier.
        for (int i = 0; i < CR - 1; i++) send(10'h354, 0, 2'b00, 8'h00);
        idle();
        check("prelock_aligned", aligned, 0);
        send(10'h354, 0, 2'b00, 8'h00);
        idle();
        check("lock8_aligned", aligned, 1);
        check("lock_no_bitslip", slip_seen, 0);

        // Decode, with explicit two-cycle latency probe on the first word.
        idle(); idle();
        send(10'h100, 1, 2'b00, 8'h00);
        idle();
        check("lat_cycle1_valid", out_valid, 0);
        idle();
        check("lat_cycle2_valid", out_valid, 1);
        idle();
        check("lat_cycle3_valid", out_valid, 0);
        send(10'h2FF, 1, 2'b00, 8'hFE);
        send(10'h0AB, 0, 2'b01, 8'h00);
        send(10'h154, 0, 2'b10, 8'h00);
        send(10'h1FF, 1, 2'b10, 8'h01);
        send(10'h2AB, 0, 2'b11, 8'h00);
        send(10'h155, 1, 2'b11, 8'hFF);
        send(10'h0F0, 1, 2'b11, 8'hEE);
        idle(); idle(); idle();

        // Lock losses; err_clr on the 4th loss wins over the increment.
        lose(1'b0);
        check("err_cnt_1", err_cnt, ERR_EN ? 1 : 0);
        lock(); lose(1'b0);
        lock(); lose(1'b0);
        idle();
        check("err_cnt_3", err_cnt, ERR_EN ? 3 : 0);
        lock(); lose(1'b1);
        idle();
        check("err_cnt_clr", err_cnt, 0);
        check("loss_no_bitslip", slip_seen, 0);

        // Alignment search: model starts 3 bits off, 7 slips bring it home.
        do_reset();
        rot = 3;
        for (int i = 0; i < 1500 && aligned !== 1'b1; i++) send(rotl(10'h354, rot), 0, 2'b00, 8'h00);
        idle();
        check("search_aligned", aligned, 1);
        check("search_slips", slip_seen, 7);
        check("search_slip_cnt", slip_cnt, 7);
        for (int i = 1; i < slip_times.size(); i++)
            check("slip_interval", slip_times[i] - slip_times[i-1], ST + SW + 1);

        // Never-aligning stream: slip_cnt wraps 9 -> 0.
        do_reset();
        for (int i = 0; i < 1000 && slip_seen < 9; i++) send(10'h000, 0, 2'b00, 8'h00);
        idle();
        check("wrap_slip_cnt9", slip_cnt, 9);
        for (int i = 0; i < 200 && slip_seen < 10; i++) send(10'h000, 0, 2'b00, 8'h00);
        idle();
        check("wrap_slip_cnt0", slip_cnt, 0);
        check("wrap_aligned", aligned, 0);

        // raw_valid gap inside WAIT stretches the slip spacing by its length.
        do_reset();
        for (int i = 0; i < 200 && slip_seen < 1; i++) send(10'h000, 0, 2'b00, 8'h00);
        for (int i = 0; i < 8; i++) send(10'h000, 0, 2'b00, 8'h00);
        repeat (5) idle();
        for (int i = 0; i < 200 && slip_seen < 2; i++) send(10'h000, 0, 2'b00, 8'h00);
        n = (slip_times.size() >= 2) ? slip_times[1] - slip_times[0] : -1;
        check("wait_gap_interval", n, ST + SW + 1 + 5);

        // Reset mid-WAIT, then the FSM must lock from SEARCH.
        for (int i = 0; i < 4; i++) send(10'h000, 0, 2'b00, 8'h00);
        do_reset();
        check_all_zero("midwait_reset");
        lock();
        check("post_reset_no_bitslip", slip_seen, 0);

        repeat (4) idle();
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
